// File: rtl/alu_pkg.sv
// Shared ALU definitions: state encoding for the sequential shifter,
// default operand widths and ALU operation codes for the future alu top.
package alu_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    typedef enum logic [3:0] {
        ALU_SRL = 4'd5,
        ALU_SRA = 4'd13
    } alu_op_t;

endpackage

// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit per clock, logical or arithmetic,
// with a valid/ready handshake on both the request and result sides.
module shift_right_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             busy
);

    shift_state_t       state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic               fill;

    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   shifted;
    logic               unused_rs2_hi;

    // Decode the request amount and the next one-bit shift of the working value.
    always_comb begin
        amt     = rs2[SHAMT_W-1:0];
        shifted = {fill, work[WIDTH-1:1]};
    end

    // Only the low SHAMT_W bits of rs2 carry the shift amount.
    assign unused_rs2_hi = ^rs2[WIDTH-1:SHAMT_W];

    // Handshake flags follow directly from the registered state.
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Control FSM with the counter, working register and registered result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            fill      <= 1'b0;
            rd        <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= rs1;
                        fill <= arith & rs1[WIDTH-1];
                        if (amt == '0) begin
                            cnt       <= '0;
                            rd        <= rs1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= amt;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        rd        <= shifted;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: expected results and latencies are
// queued when a request is driven and compared when out_valid appears.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        busy;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference for the shift result.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic ar);
        logic signed [31:0] s;
        int unsigned n;
        s = a;
        n = b % 32;
        return ar ? 32'(s >>> n) : (a >> n);
    endfunction

    // Called with clk low. Drives one request, waits for the result, optionally
    // stalls the consumer for 'hold' cycles, then retires it.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ar,
                         input int unsigned hold, input bit scramble, input string tag);
        exp_t e;
        int unsigned cyc;
        e.res = model(a, b, ar);
        e.lat = (b % 32) + 1;
        sb.push_back(e);
        rs1 = a; rs2 = b; arith = ar; in_valid = 1'b1;
        out_ready = (hold == 0);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        cyc = 1;
        if (scramble) begin
            rs1 = $urandom; rs2 = $urandom; arith = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        while (!out_valid && cyc < 200) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (scramble) begin
                rs1 = $urandom; rs2 = $urandom; arith = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " rd"}, 64'(rd), 64'(e.res));
        check({tag, " latency"}, 64'(cyc), 64'(e.lat));
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk); @(negedge clk);
            check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold rd"}, 64'(rd), 64'(e.res));
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        // A competing request presented on the retire edge must be ignored.
        out_ready = 1'b1;
        in_valid = 1'b1;
        rs1 = 32'hDEAD_BEEF; rs2 = 32'd3; arith = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check({tag, " retire out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " retire in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " retire busy"}, 64'(busy), 64'd0);
        check({tag, " retained rd"}, 64'(rd), 64'(e.res));
    endtask

    initial begin
        bit seen;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; arith = 1'b0;

        #3;
        check("reset rd", 64'(rd), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        do_op(32'h8000_0000, 32'd4,    1'b0, 0, 1'b0, "srl4");
        do_op(32'h8000_0000, 32'd4,    1'b1, 0, 1'b0, "sra4");
        do_op(32'h8000_0000, 32'd31,   1'b1, 0, 1'b0, "sra31");
        do_op(32'h0000_0100, 32'h25,   1'b0, 0, 1'b0, "amt_mask");
        do_op(32'h1234_5678, 32'd0,    1'b1, 0, 1'b0, "amt0");
        do_op(32'h7FFF_FFFF, 32'd31,   1'b1, 0, 1'b0, "sra31_pos");
        do_op(32'hF0F0_0F0F, 32'd7,    1'b1, 3, 1'b0, "stall");

        // Reset in the middle of a 20-bit shift discards the operation.
        rs1 = 32'hC000_00F0; rs2 = 32'd20; arith = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        check("midshift busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midshift rst rd", 64'(rd), 64'd0);
        check("midshift rst out_valid", 64'(out_valid), 64'd0);
        check("midshift rst busy", 64'(busy), 64'd0);
        check("midshift rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no late out_valid", 64'(seen), 64'd0);

        do_op(32'h8765_4321, 32'd12,   1'b1, 0, 1'b0, "after_reset");
        do_op(32'hA5A5_5A5A, 32'd9,    1'b1, 0, 1'b1, "busy_ignore");
        do_op(32'h0000_FFFF, 32'd16,   1'b0, 0, 1'b1, "busy_ignore2");

        for (int i = 0; i < 6; i++) begin
            do_op($urandom, $urandom, 1'($urandom), 0, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
